div_unit: RTL and testbench
===========================

// Module: div_unit
//
// PURPOSE
// - Iterative radix-2 restoring divider for MIPS DIV/DIVU. It is the sequential
//   counterpart to the ALU's single-cycle multiply.
// - Sits beside the ALU in EX. It accepts operands on a start pulse, runs a
//   fixed number of cycles, and returns quotient (LO) and remainder (HI) with
//   a one-cycle done pulse.
//
// PARAMETERS
// - WIDTH  32  operand/result width; the iteration count equals WIDTH.
//
// PORTS
// - clk            in   1      system clock; all state changes on the rising edge
// - rst_n          in   1      asynchronous, active-low reset
// - div_start      in   1      request; sampled only when div_busy=0
// - div_signed     in   1      1 = DIV (two's complement), 0 = DIVU; sampled with start
// - div_abort      in   1      pipeline flush; kills any operation in progress
// - div_op_x       in   WIDTH  dividend; sampled with start
// - div_op_y       in   WIDTH  divisor; sampled with start
// - div_busy       out  1      operation in progress
// - div_done       out  1      one-cycle pulse when results become valid
// - div_by_zero    out  1      divisor was zero; valid from div_done, held with results
// - div_quotient   out  WIDTH  quotient (LO)
// - div_remainder  out  WIDTH  remainder (HI)
//
// BEHAVIOUR
// - Reset (rst_n=0, async):
//   - State = IDLE.
//   - div_busy, div_done, div_by_zero = 0.
//   - div_quotient, div_remainder = 0.
// - States:
//   - IDLE -> CALC on start accept.
//   - CALC runs WIDTH iterations, counting 0..WIDTH-1, then -> FIX.
//   - FIX -> IDLE, asserting div_done on that edge.
// - Start accept:
//   - Condition: IDLE && div_start && !div_abort.
//   - Latches the magnitudes of x/y (abs value when div_signed and MSB=1), the
//     sign flags, and the zero-divisor flag.
//   - div_busy goes 1 on the accept edge.
// - CALC (each cycle):
//   - {rem,quo} shift left by 1.
//   - Trial rem - divisor: if non-negative, keep it and set quo[0]=1.
//   - Use a WIDTH+1-bit subtractor; no truncation.
// - FIX:
//   - Quotient is negated if the signs differ (signed only).
//   - Remainder takes the dividend's sign (signed only).
//   - Results, div_by_zero and div_done=1 are registered on this edge.
//   - div_busy drops on the same edge.
// - Latency:
//   - Accept on edge E0; div_done is high during the cycle after edge E0+WIDTH+1.
//   - That is WIDTH+2 edges start-to-idle for WIDTH=32: 34 clocks.
// - Result hold:
//   - div_quotient, div_remainder and div_by_zero stay stable until the next FIX.
//   - div_done is high for exactly 1 cycle.
// - Back-to-back: div_start in the div_done cycle is accepted, because the
//   state is IDLE.
// - Ignored starts: div_start while busy is ignored (no queueing).
// - Abort:
//   - div_abort in CALC/FIX -> IDLE next edge; busy=0; no div_done.
//   - Result outputs are unchanged.
//   - Abort in the same cycle as start while IDLE: abort wins and nothing is
//     accepted.
// - Signed overflow: 0x80000000 / 0xFFFFFFFF gives quotient 0x80000000,
//   remainder 0. No exception.
// - Divide by zero:
//   - div_by_zero=1, quotient=all-ones, remainder=dividend (original, unsigned
//     bits).
//   - Independent of div_signed.
// - Reset mid-operation: immediate return to IDLE; outputs take reset values.
//
// CONFIGURATION
// - DIV_ZERO_FAST_EN defined:
//   - A zero divisor skips CALC: IDLE -> FIX directly.
//   - div_done is high after edge E0+1 (2-cycle latency), with the same
//     divide-by-zero results.
// - DIV_ZERO_FAST_EN undefined: a zero divisor runs the full WIDTH iterations
//   (34-cycle latency) with identical results.
//
// TESTING
// - T1, unsigned: DIVU x=100, y=7 -> after 34 clocks, done=1, q=14, r=2,
//   by_zero=0.
// - T2, signed mixed signs: DIV x=-7 (0xFFFFFFF9), y=2 -> q=0xFFFFFFFD (-3),
//   r=0xFFFFFFFF (-1).
// - T3, signed overflow: DIV x=0x80000000, y=0xFFFFFFFF -> q=0x80000000, r=0.
//   Then start in the done cycle with DIVU 9/3 -> q=3, r=0 after 34 clocks.
// - T4, divide by zero: DIVU x=0x1234, y=0 -> by_zero=1, q=0xFFFFFFFF,
//   r=0x1234. Done after 2 clocks with DIV_ZERO_FAST_EN, 34 without.
// - T5, abort and ignored start: start 100/7, pulse div_start again at clock
//   5, abort at clock 10 -> busy=0 at clock 11, no done, outputs keep the
//   prior values. A new start then completes normally.
// - T6, reset mid-op: rst_n=0 at clock 15 of a division -> busy, done,
//   q, r = 0 immediately (async). No done after release.

Source files
------------

// File: rtl/div_if.sv
// Handshake and result bundle between the EX-stage issuer and the iterative divider.
interface div_if #(parameter int WIDTH = 32);
  logic             div_start;
  logic             div_signed;
  logic             div_abort;
  logic [WIDTH-1:0] div_op_x;
  logic [WIDTH-1:0] div_op_y;
  logic             div_busy;
  logic             div_done;
  logic             div_by_zero;
  logic [WIDTH-1:0] div_quotient;
  logic [WIDTH-1:0] div_remainder;

  modport master (
    output div_start, div_signed, div_abort, div_op_x, div_op_y,
    input  div_busy, div_done, div_by_zero, div_quotient, div_remainder
  );

  modport slave (
    input  div_start, div_signed, div_abort, div_op_x, div_op_y,
    output div_busy, div_done, div_by_zero, div_quotient, div_remainder
  );
endinterface

// File: rtl/div_unit.sv
// Iterative radix-2 restoring divider for MIPS DIV/DIVU (quotient -> LO, remainder -> HI).
// Optional DIV_ZERO_FAST_EN: a zero divisor skips the iteration phase.
//
// state | meaning
// IDLE  | waiting for an accepted start; results held
// CALC  | one restoring iteration per cycle, WIDTH cycles
// FIX   | sign correction, results and done registered
module div_unit #(
  parameter int WIDTH = 32
) (
  input logic   clk,
  input logic   rst_n,
  div_if.slave  bus
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH-1:0] x_raw_q, x_raw_d;
  logic             neg_quo_q, neg_quo_d;
  logic             neg_rem_q, neg_rem_d;
  logic             zero_q, zero_d;
  logic [WIDTH-1:0] res_quo_q, res_quo_d;
  logic [WIDTH-1:0] res_rem_q, res_rem_d;
  logic             by_zero_q, by_zero_d;
  logic             done_q, done_d;

  logic [WIDTH:0]   trial;
  logic [WIDTH-1:0] x_abs, y_abs;
  logic             x_neg, y_neg, y_zero, skip_calc;

  assign x_neg  = bus.div_signed & bus.div_op_x[WIDTH-1];
  assign y_neg  = bus.div_signed & bus.div_op_y[WIDTH-1];
  assign x_abs  = x_neg ? -bus.div_op_x : bus.div_op_x;
  assign y_abs  = y_neg ? -bus.div_op_y : bus.div_op_y;
  assign y_zero = (bus.div_op_y == '0);

`ifdef DIV_ZERO_FAST_EN
  assign skip_calc = y_zero;
`else
  assign skip_calc = 1'b0;
`endif

  // Shifted-in partial remainder is WIDTH+1 bits wide, so the borrow is exact.
  assign trial = {rem_q, quo_q[WIDTH-1]} - {1'b0, dvs_q};

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    dvs_d     = dvs_q;
    x_raw_d   = x_raw_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    zero_d    = zero_q;
    res_quo_d = res_quo_q;
    res_rem_d = res_rem_q;
    by_zero_d = by_zero_q;
    done_d    = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.div_start && !bus.div_abort) begin
          state_d   = skip_calc ? FIX : CALC;
          cnt_d     = '0;
          rem_d     = '0;
          quo_d     = x_abs;
          dvs_d     = y_abs;
          x_raw_d   = bus.div_op_x;
          neg_quo_d = x_neg ^ y_neg;
          neg_rem_d = x_neg;
          zero_d    = y_zero;
        end
      end
      CALC: begin
        if (bus.div_abort) begin
          state_d = IDLE;
        end else begin
          if (!trial[WIDTH]) begin
            rem_d = trial[WIDTH-1:0];
            quo_d = {quo_q[WIDTH-2:0], 1'b1};
          end else begin
            rem_d = {rem_q[WIDTH-2:0], quo_q[WIDTH-1]};
            quo_d = {quo_q[WIDTH-2:0], 1'b0};
          end
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == CW'(WIDTH - 1)) begin
            state_d = FIX;
          end
        end
      end
      FIX: begin
        if (bus.div_abort) begin
          state_d = IDLE;
        end else begin
          state_d   = IDLE;
          done_d    = 1'b1;
          by_zero_d = zero_q;
          if (zero_q) begin
            res_quo_d = '1;
            res_rem_d = x_raw_q;
          end else begin
            res_quo_d = neg_quo_q ? -quo_q : quo_q;
            res_rem_d = neg_rem_q ? -rem_q : rem_q;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      dvs_q     <= '0;
      x_raw_q   <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      zero_q    <= 1'b0;
      res_quo_q <= '0;
      res_rem_q <= '0;
      by_zero_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      dvs_q     <= dvs_d;
      x_raw_q   <= x_raw_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      zero_q    <= zero_d;
      res_quo_q <= res_quo_d;
      res_rem_q <= res_rem_d;
      by_zero_q <= by_zero_d;
      done_q    <= done_d;
    end
  end

  assign bus.div_busy      = (state_q != IDLE);
  assign bus.div_done      = done_q;
  assign bus.div_by_zero   = by_zero_q;
  assign bus.div_quotient  = res_quo_q;
  assign bus.div_remainder = res_rem_q;
endmodule

// File: tb/tb_div_unit.sv
// Scoreboard bench for div_unit: arithmetic reference model, randomized operands.
module tb_div_unit;
  localparam int WIDTH = 32;
`ifdef DIV_ZERO_FAST_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif

  typedef struct {
    logic [31:0] q;
    logic [31:0] r;
    logic        z;
    int          due;
  } exp_t;

  logic clk;
  logic rst_n;
  int   cyc;
  int   checks;
  int   failures;
  exp_t sb[$];
  logic [31:0] hold_q, hold_r;
  logic        hold_z;
  logic        prev_done;

  div_if #(.WIDTH(WIDTH)) bus ();

  div_unit #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h expected=0x%08h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // Reference: MIPS semantics from plain integer arithmetic.
  function automatic exp_t model(input logic [31:0] x, input logic [31:0] y, input logic s);
    exp_t   e;
    longint sx, sy;
    e.due = 0;
    if (y == 32'd0) begin
      e.q = 32'hFFFF_FFFF;
      e.r = x;
      e.z = 1'b1;
    end else if (s) begin
      sx  = longint'($signed(x));
      sy  = longint'($signed(y));
      e.q = 32'(sx / sy);
      e.r = 32'(sx % sy);
      e.z = 1'b0;
    end else begin
      e.q = x / y;
      e.r = x % y;
      e.z = 1'b0;
    end
    return e;
  endfunction

  // Monitor: pops on every done, otherwise checks the results are held.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (bus.div_done) begin
        if (prev_done) chk("done_width", 32'd2, 32'd1);
        if (sb.size() == 0) begin
          chk("unexpected_done", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          chk("quotient", bus.div_quotient, e.q);
          chk("remainder", bus.div_remainder, e.r);
          chk("by_zero", {31'd0, bus.div_by_zero}, {31'd0, e.z});
          chk("latency", 32'(cyc), 32'(e.due));
          hold_q = e.q;
          hold_r = e.r;
          hold_z = e.z;
        end
      end else begin
        chk("hold", {bus.div_quotient ^ hold_q} | {bus.div_remainder ^ hold_r}
                    | {31'd0, bus.div_by_zero ^ hold_z}, 32'd0);
      end
      prev_done = bus.div_done;
    end else begin
      prev_done = 1'b0;
    end
  end

  // Called at posedge+1 with the unit idle; returns at posedge+1 after the accept edge.
  task automatic issue(input logic [31:0] x, input logic [31:0] y, input logic s);
    exp_t e;
    e = model(x, y, s);
    e.due = cyc + 1 + ((FAST && y == 32'd0) ? 1 : WIDTH + 1);
    bus.div_start  = 1'b1;
    bus.div_signed = s;
    bus.div_op_x   = x;
    bus.div_op_y   = y;
    sb.push_back(e);
    @(posedge clk); #1;
    bus.div_start  = 1'b0;
    chk("busy_after_accept", {31'd0, bus.div_busy}, 32'd1);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (bus.div_busy && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 100) chk("idle_timeout", 32'(n), 32'd0);
  endtask

  initial begin
    logic [31:0] x, y;
    logic        s;
    checks = 0; failures = 0;
    hold_q = '0; hold_r = '0; hold_z = 1'b0; prev_done = 1'b0;
    bus.div_start = 1'b0; bus.div_signed = 1'b0; bus.div_abort = 1'b0;
    bus.div_op_x = '0; bus.div_op_y = '0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", {31'd0, bus.div_busy}, 32'd0);
    chk("rst_done", {31'd0, bus.div_done}, 32'd0);
    chk("rst_q", bus.div_quotient, 32'd0);
    chk("rst_r", bus.div_remainder, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    issue(32'd100, 32'd7, 1'b0);
    wait_idle();
    issue(32'hFFFF_FFF9, 32'd2, 1'b1);
    wait_idle();
    issue(32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
    wait_idle();
    chk("b2b_done_cycle", {31'd0, bus.div_done}, 32'd1);
    issue(32'd9, 32'd3, 1'b0);
    wait_idle();
    issue(32'h0000_1234, 32'd0, 1'b0);
    wait_idle();
    issue(32'hFFFF_FF00, 32'd0, 1'b1);
    wait_idle();

    // Abort with an ignored restart in between.
    issue(32'd100, 32'd7, 1'b0);
    repeat (3) @(posedge clk);
    #1 bus.div_start = 1'b1;
    @(posedge clk); #1 bus.div_start = 1'b0;
    repeat (4) @(posedge clk);
    #1 bus.div_abort = 1'b1;
    @(posedge clk); #1 bus.div_abort = 1'b0;
    void'(sb.pop_back());
    chk("abort_busy", {31'd0, bus.div_busy}, 32'd0);
    chk("abort_keep_q", bus.div_quotient, hold_q);
    repeat (40) @(posedge clk);
    #1;

    // Start and abort together while idle: nothing accepted.
    bus.div_start = 1'b1; bus.div_abort = 1'b1;
    bus.div_op_x = 32'd50; bus.div_op_y = 32'd5;
    @(posedge clk); #1;
    bus.div_start = 1'b0; bus.div_abort = 1'b0;
    chk("start_abort_busy", {31'd0, bus.div_busy}, 32'd0);
    repeat (40) @(posedge clk);
    #1;
    issue(32'd100, 32'd7, 1'b0);
    wait_idle();

    // Reset mid-operation.
    issue(32'd1000, 32'd3, 1'b0);
    repeat (13) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("midrst_busy", {31'd0, bus.div_busy}, 32'd0);
    chk("midrst_done", {31'd0, bus.div_done}, 32'd0);
    chk("midrst_q", bus.div_quotient, 32'd0);
    chk("midrst_r", bus.div_remainder, 32'd0);
    sb.delete();
    hold_q = '0; hold_r = '0; hold_z = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (40) @(posedge clk);
    #1;

    for (int i = 0; i < 40; i++) begin
      x = $urandom;
      if ($urandom_range(0, 7) == 0) x = 32'h8000_0000;
      case ($urandom_range(0, 5))
        0:       y = 32'd0;
        1:       y = 32'($urandom_range(1, 15));
        2:       y = 32'hFFFF_FFFF;
        3:       y = 32'hFFFF_FFFF - 32'($urandom_range(0, 15));
        default: y = $urandom;
      endcase
      s = 1'($urandom_range(0, 1));
      issue(x, y, s);
      wait_idle();
    end

    repeat (4) @(posedge clk);
    #1;
    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
